// File: rtl/fifo_uart_arbiter_pkg.sv
// Shared types for the FIFO-to-UART arbiter: FSM state encoding and busy-edge codes.
package fifo_uart_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_RWAIT,
    S_LOAD,
    S_TAG_DV,
    S_TAG_WAIT,
    S_DAT_DV,
    S_DAT_WAIT
  } state_e;

  // {prev_busy, busy} edge encodings
  localparam logic [1:0] LOW     = 2'b00;
  localparam logic [1:0] RISING  = 2'b01;
  localparam logic [1:0] HIGH    = 2'b11;
  localparam logic [1:0] FALLING = 2'b10;

endpackage

// File: rtl/fifo_uart_arbiter_if.sv
// FIFO-side and UART-side signals of the arbiter; master = arbiter, slave = environment.
interface fifo_uart_arbiter_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_CH  = 4
);
  localparam int unsigned IDW = $clog2(N_CH);

  logic                  i_tx_enable;
  logic [N_CH-1:0]       i_empty;
  logic [N_CH*WIDTH-1:0] i_r_data;
  logic [N_CH-1:0]       o_r_en;
  logic                  i_busy;
  logic                  o_dv;
  logic [WIDTH-1:0]      o_data;
  logic [IDW-1:0]        o_grant_id;
  logic                  o_active;
  logic                  o_timeout;

  modport master (
    input  i_tx_enable, i_empty, i_r_data, i_busy,
    output o_r_en, o_dv, o_data, o_grant_id, o_active, o_timeout
  );

  modport slave (
    output i_tx_enable, i_empty, i_r_data, i_busy,
    input  o_r_en, o_dv, o_data, o_grant_id, o_active, o_timeout
  );
endinterface

// File: rtl/fifo_uart_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after the pointer, wrapping.
module rr_arbiter #(
  parameter int unsigned N_CH = 4
) (
  input  logic [N_CH-1:0]         i_req,
  input  logic [$clog2(N_CH)-1:0] i_ptr,
  output logic [$clog2(N_CH)-1:0] o_grant,
  output logic                    o_valid
);
  localparam int unsigned IDW   = $clog2(N_CH);
  localparam logic [IDW:0] NCH_W = (IDW+1)'(N_CH);

  logic [IDW:0] w_idx;

  // Scan from farthest to nearest so the nearest requester is written last and wins
  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    for (int i = N_CH; i >= 1; i--) begin
      w_idx = {1'b0, i_ptr} + (IDW+1)'(i);
      if (w_idx >= NCH_W) w_idx = w_idx - NCH_W;
      if (i_req[w_idx[IDW-1:0]]) begin
        o_grant = w_idx[IDW-1:0];
        o_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fifo_uart_arbiter.sv
// Round-robin arbiter feeding one UART transmitter from N_CH byte FIFOs, with optional tag word.
module fifo_uart_arbiter
  import fifo_uart_arb_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned N_CH     = 4,
  parameter int unsigned RD_LAT   = 2,
  parameter int unsigned TAG_EN   = 1,
  parameter int unsigned TAG_BASE = 32'hF0,
  parameter int unsigned TIMEOUT  = 1024
) (
  input logic                 clk,
  input logic                 i_reset_n,
  fifo_uart_arbiter_if.master bus
);
  localparam int unsigned IDW      = $clog2(N_CH);
  localparam int unsigned LW       = $clog2(RD_LAT + 1);
  localparam int unsigned TOW      = $clog2(TIMEOUT);
  localparam int unsigned LAT_LAST = (RD_LAT > 1) ? RD_LAT - 2 : 0;

  state_e           r_state, w_state_nxt;
  logic [N_CH-1:0]  r_r_en, w_r_en_nxt;
  logic             r_dv, w_dv_nxt;
  logic [WIDTH-1:0] r_data, w_data_nxt;
  logic [IDW-1:0]   r_grant_id, w_grant_nxt;
  logic [IDW-1:0]   r_ptr, w_ptr_nxt;
  logic             r_active, w_active_nxt;
  logic             r_timeout, w_timeout_nxt;
  logic [LW-1:0]    r_lat_cnt, w_lat_nxt;
  logic [TOW-1:0]   r_to_cnt, w_to_nxt;
  logic [WIDTH-1:0] r_word, w_word_nxt;
  logic             r_prev_busy;

  logic [IDW-1:0]   w_arb_grant;
  logic             w_arb_valid;
  logic [1:0]       w_edge;
  logic             w_rise, w_fall;
  logic [WIDTH-1:0] w_words [N_CH];

  for (genvar k = 0; k < N_CH; k++) begin : g_words
    assign w_words[k] = bus.i_r_data[k*WIDTH +: WIDTH];
  end

  rr_arbiter #(.N_CH(N_CH)) u_rr (
    .i_req   (~bus.i_empty),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_grant),
    .o_valid (w_arb_valid)
  );

  assign w_edge = {r_prev_busy, bus.i_busy};

  always_comb begin
    w_rise = 1'b0;
    w_fall = 1'b0;
    unique case (w_edge)
      RISING:    w_rise = 1'b1;
      FALLING:   w_fall = 1'b1;
      LOW, HIGH: ;
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_r_en_nxt    = '0;
    w_dv_nxt      = r_dv;
    w_data_nxt    = r_data;
    w_grant_nxt   = r_grant_id;
    w_ptr_nxt     = r_ptr;
    w_timeout_nxt = 1'b0;
    w_lat_nxt     = r_lat_cnt;
    w_to_nxt      = r_to_cnt;
    w_word_nxt    = r_word;
    case (r_state)
      S_IDLE: begin
        if (bus.i_tx_enable && !bus.i_busy && w_arb_valid) begin
          w_state_nxt = S_READ;
          w_grant_nxt = w_arb_grant;
          w_ptr_nxt   = w_arb_grant;
          w_r_en_nxt  = N_CH'(1) << w_arb_grant;
        end
      end
      S_READ: begin
        w_lat_nxt   = '0;
        w_state_nxt = (RD_LAT > 1) ? S_RWAIT : S_LOAD;
      end
      S_RWAIT: begin
        if (r_lat_cnt == LW'(LAT_LAST)) w_state_nxt = S_LOAD;
        else                            w_lat_nxt   = r_lat_cnt + LW'(1);
      end
      S_LOAD: begin
        w_word_nxt = w_words[r_grant_id];
        w_to_nxt   = '0;
        w_dv_nxt   = 1'b1;
        if (TAG_EN != 0) begin
          w_state_nxt = S_TAG_DV;
          w_data_nxt  = WIDTH'(TAG_BASE) + WIDTH'(r_grant_id);
        end else begin
          w_state_nxt = S_DAT_DV;
          w_data_nxt  = w_words[r_grant_id];
        end
      end
      // A busy rise takes priority over a timeout landing in the same clk
      S_TAG_DV, S_DAT_DV: begin
        if (w_rise) begin
          w_dv_nxt    = 1'b0;
          w_state_nxt = (r_state == S_TAG_DV) ? S_TAG_WAIT : S_DAT_WAIT;
        end else if (r_to_cnt == TOW'(TIMEOUT - 1)) begin
          w_dv_nxt      = 1'b0;
          w_timeout_nxt = 1'b1;
          w_state_nxt   = S_IDLE;
        end else begin
          w_to_nxt = r_to_cnt + TOW'(1);
        end
      end
      S_TAG_WAIT: begin
        if (w_fall) begin
          w_state_nxt = S_DAT_DV;
          w_dv_nxt    = 1'b1;
          w_data_nxt  = r_word;
          w_to_nxt    = '0;
        end
      end
      S_DAT_WAIT: begin
        if (w_fall) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_active_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= S_IDLE;
      r_r_en      <= '0;
      r_dv        <= 1'b0;
      r_data      <= '0;
      r_grant_id  <= '0;
      r_ptr       <= IDW'(N_CH - 1);
      r_active    <= 1'b0;
      r_timeout   <= 1'b0;
      r_lat_cnt   <= '0;
      r_to_cnt    <= '0;
      r_word      <= '0;
      r_prev_busy <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_r_en      <= w_r_en_nxt;
      r_dv        <= w_dv_nxt;
      r_data      <= w_data_nxt;
      r_grant_id  <= w_grant_nxt;
      r_ptr       <= w_ptr_nxt;
      r_active    <= w_active_nxt;
      r_timeout   <= w_timeout_nxt;
      r_lat_cnt   <= w_lat_nxt;
      r_to_cnt    <= w_to_nxt;
      r_word      <= w_word_nxt;
      r_prev_busy <= bus.i_busy;
    end
  end

  assign bus.o_r_en     = r_r_en;
  assign bus.o_dv       = r_dv;
  assign bus.o_data     = r_data;
  assign bus.o_grant_id = r_grant_id;
  assign bus.o_active   = r_active;
  assign bus.o_timeout  = r_timeout;

endmodule

// File: tb/tb_fifo_uart_arbiter.sv
// Scoreboard bench: directed FIFO loads push expected UART words and read strobes; monitors pop and compare.
module tb_fifo_uart_arbiter;
  localparam int unsigned WIDTH   = 8;
  localparam int unsigned N_CH    = 4;
  localparam int unsigned RD_LAT  = 2;
  localparam int unsigned TIMEOUT = 16;
  localparam logic [7:0]  TAG_B   = 8'hF0;
  localparam logic [7:0]  JUNK    = 8'hEE;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] ch;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifo_uart_arbiter_if #(.WIDTH(WIDTH), .N_CH(N_CH)) bus ();

  fifo_uart_arbiter #(
    .WIDTH(WIDTH), .N_CH(N_CH), .RD_LAT(RD_LAT), .TAG_EN(1),
    .TAG_BASE(32'hF0), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk      (clk),
    .i_reset_n(rst_n),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  exp_t       exp_uart [$];
  logic [1:0] exp_ren  [$];
  logic [7:0] fifo_q   [4][$];

  logic       uart_mute = 1'b0;
  int         busy_cnt  = 0;
  int         to_pulses = 0;
  int         pend_cnt  = 0;
  logic [1:0] pend_ch   = '0;
  logic [7:0] pend_data = '0;
  logic [7:0] rd_slot [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [1:0] ch, input logic [7:0] d);
    fifo_q[ch].push_back(d);
  endtask

  task automatic expect_frame(input logic [1:0] ch, input logic [7:0] d);
    exp_t e;
    e.ch   = ch;
    e.data = TAG_B + 8'(ch);
    exp_uart.push_back(e);
    e.data = d;
    exp_uart.push_back(e);
    exp_ren.push_back(ch);
  endtask

  task automatic drain(input string name);
    int c = 0;
    while ((exp_uart.size() != 0 || exp_ren.size() != 0 || bus.o_active || busy_cnt != 0) && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check(name, 32'(c < 2000), 32'd1);
  endtask

  // FIFO model: data appears RD_LAT clks after the strobe for exactly one clk, junk otherwise
  always @(negedge clk) begin
    logic [3:0] emp;
    for (int k = 0; k < 4; k++) rd_slot[2'(k)] = JUNK;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) rd_slot[pend_ch] = pend_data;
    end
    if (rst_n && bus.o_r_en != '0) begin
      for (int k = 0; k < 4; k++) begin
        if (bus.o_r_en[2'(k)]) begin
          pend_ch   = 2'(k);
          pend_data = JUNK;
          if (fifo_q[2'(k)].size() > 0) pend_data = fifo_q[2'(k)].pop_front();
        end
      end
      pend_cnt = RD_LAT;
    end
    bus.i_r_data = {rd_slot[3], rd_slot[2], rd_slot[1], rd_slot[0]};
    for (int k = 0; k < 4; k++) emp[2'(k)] = (fifo_q[2'(k)].size() == 0);
    bus.i_empty = emp;
  end

  // UART model and word monitor
  always @(negedge clk) begin
    if (busy_cnt > 0) begin
      busy_cnt--;
    end else if (!uart_mute && rst_n && bus.o_dv) begin
      if (exp_uart.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL uart_unexpected_word: got 0x%0h, expected no word", bus.o_data);
      end else begin
        exp_t e;
        e = exp_uart.pop_front();
        check("uart_data", 32'(bus.o_data), 32'(e.data));
        check("uart_grant_id", 32'(bus.o_grant_id), 32'(e.ch));
      end
      busy_cnt = 4;
    end
    bus.i_busy = (busy_cnt > 0);
  end

  // Read-strobe monitor
  always @(negedge clk) begin
    if (rst_n && bus.o_r_en != '0) begin
      if (exp_ren.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL r_en_unexpected: got 0x%0h, expected 0x0", bus.o_r_en);
      end else begin
        logic [3:0] oh;
        oh = 4'b0001 << exp_ren.pop_front();
        check("r_en_onehot", 32'(bus.o_r_en), 32'(oh));
      end
    end
  end

  always @(negedge clk) if (bus.o_timeout === 1'b1) to_pulses++;

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  c;
    int  dv_cnt;
    logic seen;
    rst_n = 1'b0;
    bus.i_tx_enable = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dv",       32'(bus.o_dv),       32'd0);
    check("rst_r_en",     32'(bus.o_r_en),     32'd0);
    check("rst_data",     32'(bus.o_data),     32'd0);
    check("rst_grant_id", 32'(bus.o_grant_id), 32'd0);
    check("rst_active",   32'(bus.o_active),   32'd0);
    check("rst_timeout",  32'(bus.o_timeout),  32'd0);
    rst_n = 1'b1;

    // Single channel with tag
    @(negedge clk);
    load(2'd2, 8'h5A);
    expect_frame(2'd2, 8'h5A);
    bus.i_tx_enable = 1'b1;
    drain("t1_drain");
    check("t1_grant_id", 32'(bus.o_grant_id), 32'd2);

    // All channels after reset: order 0..3
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load(2'd0, 8'h11); load(2'd1, 8'h22); load(2'd2, 8'h33); load(2'd3, 8'h44);
    expect_frame(2'd0, 8'h11); expect_frame(2'd1, 8'h22);
    expect_frame(2'd2, 8'h33); expect_frame(2'd3, 8'h44);
    drain("t2_drain");

    // Pointer wrap: last grant 1, then ch1 x3 + ch3 x1 -> 3,1,1,1
    load(2'd1, 8'h61);
    expect_frame(2'd1, 8'h61);
    drain("t3_prep_drain");
    load(2'd1, 8'hA1); load(2'd1, 8'hA2); load(2'd1, 8'hA3); load(2'd3, 8'hB3);
    expect_frame(2'd3, 8'hB3); expect_frame(2'd1, 8'hA1);
    expect_frame(2'd1, 8'hA2); expect_frame(2'd1, 8'hA3);
    drain("t3_drain");

    // Disable during TAG_WAIT: frame completes, no new grant
    load(2'd0, 8'hC0); load(2'd2, 8'hC2);
    expect_frame(2'd2, 8'hC2);
    c = 0;
    while (busy_cnt == 0 && c < 200) begin @(negedge clk); c++; end
    check("t5_tag_accepted", 32'(c < 200), 32'd1);
    @(negedge clk);
    bus.i_tx_enable = 1'b0;
    repeat (40) @(negedge clk);
    check("t5_words_left",  32'(exp_uart.size()), 32'd0);
    check("t5_ch0_pending", 32'(fifo_q[0].size()), 32'd1);
    check("t5_idle",        32'(bus.o_active), 32'd0);
    expect_frame(2'd0, 8'hC0);
    bus.i_tx_enable = 1'b1;
    drain("t5_drain");

    // Handshake timeout: UART silent
    uart_mute = 1'b1;
    load(2'd1, 8'h77);
    exp_ren.push_back(2'd1);
    dv_cnt = 0;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (bus.o_dv) begin
        dv_cnt++;
        if (dv_cnt == 1) check("t4_tag", 32'(bus.o_data), 32'hF1);
      end
      if (bus.o_timeout) begin
        seen = 1'b1;
        check("t4_dv_low_at_to",     32'(bus.o_dv),     32'd0);
        check("t4_active_low_at_to", 32'(bus.o_active), 32'd0);
      end
    end
    check("t4_timeout_seen", 32'(seen), 32'd1);
    check("t4_dv_cycles",    32'(dv_cnt), 32'd16);
    repeat (10) @(negedge clk);
    check("t4_pulses",     32'(to_pulses), 32'd1);
    check("t4_stay_idle",  32'(bus.o_active), 32'd0);
    check("t4_ren_used",   32'(exp_ren.size()), 32'd0);
    uart_mute = 1'b0;

    // Reset in DAT_DV, then first grant is ch0
    load(2'd2, 8'h99);
    begin
      exp_t e;
      e.ch = 2'd2;
      e.data = 8'hF2;
      exp_uart.push_back(e);
    end
    exp_ren.push_back(2'd2);
    c = 0;
    while (busy_cnt == 0 && c < 200) begin @(negedge clk); c++; end
    uart_mute = 1'b1;
    c = 0;
    while (!(bus.o_dv && bus.o_data == 8'h99) && c < 100) begin @(negedge clk); c++; end
    check("t6_in_dat_dv", 32'(c < 100), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_dv",     32'(bus.o_dv),     32'd0);
    check("t6_rst_r_en",   32'(bus.o_r_en),   32'd0);
    check("t6_rst_active", 32'(bus.o_active), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    uart_mute = 1'b0;
    @(negedge clk);
    load(2'd0, 8'hD0); load(2'd3, 8'hD3);
    expect_frame(2'd0, 8'hD0); expect_frame(2'd3, 8'hD3);
    drain("t6_drain");

    check("end_uart_q", 32'(exp_uart.size()), 32'd0);
    check("end_ren_q",  32'(exp_ren.size()),  32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
